// File: rtl/lbm_step_sequencer.sv
// Phase and address sequencer for the D2Q9 lattice-Boltzmann datapath.
// Read strobes go out directly; each write strobe is its read delayed PIPE_LAT cycles.
module lbm_step_sequencer #(
  parameter int NX       = 16,
  parameter int NY       = 16,
  parameter int PIPE_LAT = 4,
  parameter int ADDR_W   = $clog2(NX*NY)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [7:0]        step_count,
  output logic              busy,
  output logic              done,
  output logic [2:0]        phase,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_dir,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_dir,
  output logic              WE_p_mem,
  output logic              WE_ux_mem,
  output logic              WE_uy_mem,
  output logic              WE_fin_mem,
  output logic              WE_fout_mem,
  output logic              WE_feq_mem,
  output logic              select_init
);
  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [XW-1:0] X_MAX      = XW'(NX - 1);
  localparam logic [YW-1:0] Y_MAX      = YW'(NY - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT - 1);

  // state | meaning: IDLE wait start, INIT load ICs, MOMENT/EQUIL/COLLIDE/STREAM sweeps, DONE pulse
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_INIT, S_MOMENT, S_EQUIL, S_COLLIDE, S_STREAM, S_DONE
  } state_t;

  typedef struct packed {
    logic              vld;
    state_t            tag;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        dir;
  } wr_slot_t;

  state_t            state, state_nxt;
  logic [XW-1:0]     x, nbr_x;
  logic [YW-1:0]     y, nbr_y;
  logic [3:0]        d;
  logic              draining;
  logic [DW-1:0]     drain_cnt;
  logic [7:0]        steps_left;
  logic              sweep, last_cell, last_issue, sweep_end;
  logic              xp, xm, yp, ym;
  logic [ADDR_W-1:0] cell_addr, nbr_addr;
  wr_slot_t          pipe [PIPE_LAT];
  wr_slot_t          push_slot, wr_slot;

  always_comb begin
    sweep      = (state == S_MOMENT) || (state == S_EQUIL) ||
                 (state == S_COLLIDE) || (state == S_STREAM);
    last_cell  = (x == X_MAX) && (y == Y_MAX);
    last_issue = last_cell && ((state != S_STREAM) || (d == 4'd8));
    sweep_end  = sweep && draining && (drain_cnt == '0);
    rd_en      = sweep && !draining;

    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_INIT;
      S_INIT:    if (last_cell) state_nxt = (steps_left == 8'd0) ? S_DONE : S_MOMENT;
      S_MOMENT:  if (sweep_end) state_nxt = S_EQUIL;
      S_EQUIL:   if (sweep_end) state_nxt = S_COLLIDE;
      S_COLLIDE: if (sweep_end) state_nxt = S_STREAM;
      S_STREAM:  if (sweep_end) state_nxt = (steps_left > 8'd1) ? S_MOMENT : S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Periodic neighbour by compare/select on the D2Q9 velocity components.
  always_comb begin
    xp = (d == 4'd1) || (d == 4'd5) || (d == 4'd8);
    xm = (d == 4'd3) || (d == 4'd6) || (d == 4'd7);
    yp = (d == 4'd2) || (d == 4'd5) || (d == 4'd6);
    ym = (d == 4'd4) || (d == 4'd7) || (d == 4'd8);
    nbr_x = x;
    if (xp)      nbr_x = (x == X_MAX) ? '0 : x + XW'(1);
    else if (xm) nbr_x = (x == '0) ? X_MAX : x - XW'(1);
    nbr_y = y;
    if (yp)      nbr_y = (y == Y_MAX) ? '0 : y + YW'(1);
    else if (ym) nbr_y = (y == '0) ? Y_MAX : y - YW'(1);
    cell_addr = ADDR_W'(y) * ADDR_W'(NX) + ADDR_W'(x);
    nbr_addr  = ADDR_W'(nbr_y) * ADDR_W'(NX) + ADDR_W'(nbr_x);

    push_slot = '0;
    if (rd_en) begin
      push_slot.vld  = 1'b1;
      push_slot.tag  = state;
      push_slot.addr = (state == S_STREAM) ? nbr_addr : cell_addr;
      push_slot.dir  = (state == S_STREAM) ? d : 4'd0;
    end
    wr_slot = pipe[PIPE_LAT-1];
  end

  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    phase       = state;
    select_init = (state == S_INIT);
    rd_addr     = rd_en ? cell_addr : '0;
    rd_dir      = (rd_en && state == S_STREAM) ? d : 4'd0;
    wr_addr     = select_init ? cell_addr : wr_slot.addr;
    wr_dir      = select_init ? 4'd0 : wr_slot.dir;
    WE_p_mem    = select_init || (wr_slot.vld && wr_slot.tag == S_MOMENT);
    WE_ux_mem   = WE_p_mem;
    WE_uy_mem   = WE_p_mem;
    WE_fin_mem  = select_init || (wr_slot.vld && wr_slot.tag == S_STREAM);
    WE_feq_mem  = wr_slot.vld && wr_slot.tag == S_EQUIL;
    WE_fout_mem = wr_slot.vld && wr_slot.tag == S_COLLIDE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      x          <= '0;
      y          <= '0;
      d          <= '0;
      draining   <= 1'b0;
      drain_cnt  <= '0;
      steps_left <= '0;
    end else begin
      if (state == S_IDLE && start)
        steps_left <= step_count;
      else if (state == S_STREAM && sweep_end)
        steps_left <= steps_left - 8'd1;

      if (state_nxt != state) begin
        x         <= '0;
        y         <= '0;
        d         <= '0;
        draining  <= 1'b0;
        drain_cnt <= '0;
      end else if (rd_en || state == S_INIT) begin
        if (rd_en && last_issue) begin
          draining  <= 1'b1;
          drain_cnt <= DRAIN_INIT;
        end
        if (state == S_STREAM && d != 4'd8) begin
          d <= d + 4'd1;
        end else begin
          d <= '0;
          if (x == X_MAX) begin
            x <= '0;
            y <= (y == Y_MAX) ? '0 : y + YW'(1);
          end else begin
            x <= x + XW'(1);
          end
        end
      end else if (draining) begin
        drain_cnt <= drain_cnt - DW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= push_slot;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Directed bench for lbm_step_sequencer on a 4x4 grid with a 2-cycle pipe.
// Reads are modelled independently; expected writes are queued and matched PIPE_LAT later.
module tb_lbm_step_sequencer;
  localparam int NX = 4, NY = 4, PL = 2, AW = 4, N = NX*NY;

  logic          Clk = 1'b0;
  logic          Reset, start;
  logic [7:0]    step_count;
  logic          busy, done, rd_en, select_init;
  logic [2:0]    phase;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [3:0]    rd_dir, wr_dir;
  logic          WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem;

  lbm_step_sequencer #(.NX(NX), .NY(NY), .PIPE_LAT(PL), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .step_count(step_count),
    .busy(busy), .done(done), .phase(phase),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dir(rd_dir),
    .wr_addr(wr_addr), .wr_dir(wr_dir),
    .WE_p_mem(WE_p_mem), .WE_ux_mem(WE_ux_mem), .WE_uy_mem(WE_uy_mem),
    .WE_fin_mem(WE_fin_mem), .WE_fout_mem(WE_fout_mem), .WE_feq_mem(WE_feq_mem),
    .select_init(select_init)
  );

  always #5 Clk = ~Clk;

  typedef struct { int due; int tag; int src; int sdir; int addr; int dir; } exp_t;
  exp_t sbq[$];
  int   phase_log[$];
  int   len_log[$];
  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, prev_phase = 0, phase_cyc = 0, rd_idx = 0, fout_n = 0, fin_n = 0;
  int   ex [9] = '{0, 1, 0, -1, 0, 1, -1, -1, 1};
  int   ey [9] = '{0, 0, 1, 0, -1, 1, 1, -1, -1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int nbr(input int a, input int dd);
    int x, y;
    x = a % NX;
    y = a / NX;
    return ((y + ey[dd] + NY) % NY) * NX + ((x + ex[dd] + NX) % NX);
  endfunction

  function automatic logic [5:0] we_of(input int tag);
    case (tag)
      2:       return 6'b111000;
      3:       return 6'b000001;
      4:       return 6'b000010;
      5:       return 6'b000100;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic int len_of(input int ph);
    case (ph)
      1:       return N;
      2, 3, 4: return N + PL;
      5:       return 9*N + PL;
      6:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] outs();
    return {3'b0, busy, done, phase, rd_en, rd_addr, rd_dir, wr_addr, wr_dir,
            WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem, select_init};
  endfunction

  task automatic monitor();
    logic [5:0] we;
    exp_t       e;
    int         ph, ea, ed;
    logic       exp_rd;
    we = {WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem};
    ph = int'(phase);
    if (ph != prev_phase) begin
      phase_log.push_back(ph);
      len_log.push_back(phase_cyc + 1);
      prev_phase = ph;
      phase_cyc  = 0;
      rd_idx     = 0;
    end else begin
      phase_cyc++;
    end
    if (WE_fout_mem) fout_n++;
    if (WE_fin_mem)  fin_n++;
    chk("select_init", select_init, ph == 1);
    chk("busy", busy, ph != 0);
    chk("done", done, ph == 6);
    exp_rd = (ph >= 2 && ph <= 5) && (phase_cyc < ((ph == 5) ? 9*N : N));
    chk("rd_en", rd_en, exp_rd);
    if (rd_en) begin
      ea = (ph == 5) ? rd_idx / 9 : rd_idx;
      ed = (ph == 5) ? rd_idx % 9 : 0;
      chk("rd_addr", rd_addr, ea);
      chk("rd_dir", rd_dir, ed);
      e.due  = cyc + PL;
      e.tag  = ph;
      e.src  = ea;
      e.sdir = ed;
      e.addr = (ph == 5) ? nbr(ea, ed) : ea;
      e.dir  = ed;
      sbq.push_back(e);
      rd_idx++;
    end
    if (ph == 1) begin
      chk("init_we", we, 6'b111100);
      chk("init_wr_addr", wr_addr, phase_cyc);
      chk("init_wr_dir", wr_dir, 0);
    end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("wr_we", we, we_of(e.tag));
      chk("wr_addr", wr_addr, e.addr);
      chk("wr_dir", wr_dir, e.dir);
      if (e.tag == 5 && e.src == 3  && e.sdir == 1) chk("wrap_x_right", wr_addr, 0);
      if (e.tag == 5 && e.src == 0  && e.sdir == 7) chk("wrap_corner", wr_addr, 15);
      if (e.tag == 5 && e.src == 12 && e.sdir == 2) chk("wrap_y_top", wr_addr, 0);
    end else begin
      chk("no_we", we, 0);
    end
  endtask

  task automatic tick();
    logic r;
    r = Reset;
    @(posedge Clk);
    #1;
    cyc++;
    if (r) sbq.delete();
    monitor();
  endtask

  task automatic run(input int steps, input bit poke);
    int   c0, tdone, busy_n;
    bit   got;
    int   exp_ph[$];
    phase_log.delete();
    len_log.delete();
    fout_n = 0;
    fin_n  = 0;
    step_count = 8'(steps);
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    got = 1'b0;
    busy_n = 0;
    tdone = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      if (busy) busy_n++;
      if (done) begin
        got = 1'b1;
        tdone = cyc;
      end else begin
        if (poke && i == 30) begin
          start = 1'b1;
          step_count = 8'd5;
        end
        tick();
        start = 1'b0;
      end
    end
    chk("done_seen", got, 1);
    chk("done_latency", tdone - c0, N + steps*(12*N + 4*PL) + 1);
    chk("busy_cycles", busy_n, N + steps*(12*N + 4*PL) + 1);
    chk("fout_writes", fout_n, N*steps);
    chk("fin_writes", fin_n, N + 9*N*steps);
    tick();
    chk("idle_after_done", phase, 0);
    exp_ph.push_back(1);
    for (int s = 0; s < steps; s++)
      for (int p = 2; p <= 5; p++) exp_ph.push_back(p);
    exp_ph.push_back(6);
    exp_ph.push_back(0);
    chk("phase_log_len", phase_log.size(), exp_ph.size());
    for (int i = 0; i < exp_ph.size() && i < phase_log.size(); i++) begin
      chk("phase_seq", phase_log[i], exp_ph[i]);
      if (i >= 1) chk("phase_len", len_log[i], len_of(exp_ph[i-1]));
    end
    chk("sb_empty", sbq.size(), 0);
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    step_count = 8'd0;
    repeat (3) tick();
    chk("rst_outputs", outs(), 0);
    Reset = 1'b0;
    tick();

    Reset = 1'b1;
    start = 1'b1;
    step_count = 8'd2;
    tick();
    Reset = 1'b0;
    start = 1'b0;
    chk("rst_wins_phase", phase, 0);
    chk("rst_wins_busy", busy, 0);
    tick();
    chk("still_idle", phase, 0);

    run(1, 1'b1);
    run(0, 1'b0);
    run(3, 1'b0);

    step_count = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && !(phase == 3'd5 && phase_cyc == 20); i++) tick();
    chk("reached_stream", phase, 5);
    chk("fin_we_in_flight", WE_fin_mem, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("mid_rst_outputs", outs(), 0);
    tick();
    chk("mid_rst_idle", outs(), 0);
    run(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lbm_step_sequencer.md
# lbm_step_sequencer

Top-level sequencer for the D2Q9 lattice-Boltzmann datapath. It owns all memory write enables, read strobes, addresses and source selects for the p, ux, uy, fin, fout and feq memories. It steps the grid through initialisation and then a programmable number of timesteps, each made of moment, equilibrium, collision and streaming sweeps. It replaces ad-hoc phase control in the datapath and compensates for the fixed compute pipeline latency.

## Interface
- NX, 16, grid width in cells
- NY, 16, grid height in cells
- PIPE_LAT, 4, cycles from read strobe to matching write strobe (≥1)
- ADDR_W, $clog2(NX*NY), cell address width
---
- Clk  in  1  clock, all logic rising-edge
- Reset  in  1  reset Reset, synchronous, active-high
- start  in  1  pulse; begin run (ignored while busy)
- step_count  in  8  timesteps to run, sampled with start
- busy  out  1  high from cycle after accepted start until DONE exits
- done  out  1  one-cycle pulse in DONE
- phase  out  3  IDLE=0 INIT=1 MOMENT=2 EQUIL=3 COLLIDE=4 STREAM=5 DONE=6
- rd_en  out  1  datapath read strobe
- rd_addr  out  ADDR_W  source cell (y*NX+x)
- rd_dir  out  4  direction 0-8 (STREAM only, else 0)
- wr_addr  out  ADDR_W  destination cell
- wr_dir  out  4  destination direction (STREAM only, else 0)
- WE_p_mem, WE_ux_mem, WE_uy_mem, WE_fin_mem, WE_fout_mem, WE_feq_mem  out  1 each  memory write enables
- select_init  out  1  1 = memories load initial-condition values; 0 = datapath results

## Operation
- FSM: IDLE -start-> INIT -> MOMENT -> EQUIL -> COLLIDE -> STREAM -> (steps_left>0 ? MOMENT : DONE) -> IDLE. step_count=0: INIT then DONE.
- steps_left loaded with step_count on accepted start; decrements on each STREAM exit.
- N = NX*NY. Cell counter runs 0..N-1, x inner, y outer.
- INIT: N cycles. Each cycle writes directly (no read). wr_addr=cell. WE_p/ux/uy/fin=1, select_init=1.
- MOMENT: reads fin; writes p, ux, uy.
- EQUIL: reads p/ux/uy; writes feq.
- COLLIDE: reads fin and feq; writes fout.
- STREAM: reads fout(cell,d); writes fin(neighbor,d). Direction is the inner loop (0..8), cell the outer loop: 9N issue cycles.
- D2Q9 vectors d0..d8: (0,0) (1,0) (0,1) (-1,0) (0,-1) (1,1) (-1,1) (-1,-1) (1,-1).
- Neighbor = ((x+ex) mod NX, (y+ey) mod NY). Periodic wrap is computed with compare/select, not division.
- Sweep phases: issue cycles with rd_en=1, then PIPE_LAT drain cycles with rd_en=0.
- Write side: each write strobe and its wr_addr/wr_dir are the read-side values delayed through a PIPE_LAT-deep shift register. The phase's WE is asserted exactly PIPE_LAT cycles after each rd_en.
- Exactly one phase's write enables are active in any cycle. select_init=0 outside INIT.

## Timing
- Reset: next edge forces IDLE, phase=0, steps_left=0, and clears counters and the delay pipeline. All outputs are 0 one cycle later, including mid-run; pending writes are discarded.
- start sampled in IDLE at cycle 0 → INIT occupies cycles 1..N.
- Sweep phase lengths:
  - MOMENT, EQUIL, COLLIDE: N+PIPE_LAT cycles each.
  - STREAM: 9N+PIPE_LAT cycles.
  - Per timestep: 12N+4·PIPE_LAT cycles.
- The next phase starts the cycle after the last drain cycle, with no gap. No write of phase k overlaps a read of phase k+1.
- DONE lasts 1 cycle with done=1, busy=1. IDLE follows; start is accepted again in that IDLE cycle.
- start while busy: no effect. start coincident with Reset: Reset wins.

## Test plan
- NX=NY=4, PIPE_LAT=2, step_count=1, start → INIT 16 cycles with WE_fin=1, select_init=1, wr_addr 0..15. done pulses exactly 16+200+1 cycles after start (counting the DONE cycle).
- Same config, MOMENT: rd_en at cycle t with rd_addr=k → WE_p/ux/uy=1 at t+2 with wr_addr=k. No WE in the last 2 cycles' read slots.
- STREAM wrap: read cell 3 (x=3,y=0) d1 → wr_addr=0, wr_dir=1. Read cell 0 d7 → wr_addr=15. Read cell 12 d2 → wr_addr=0.
- step_count=0 → INIT then DONE; no MOMENT phase observed, no WE_fout.
- step_count=3 → phase sequence 2,3,4,5 repeats 3 times; total busy cycles 16+600+1.
- Reset asserted mid-STREAM with writes in flight → all WE/rd_en=0 next cycle, phase=0. A fresh start then begins INIT normally.
